bias_weight_updater: RTL and testbench

Training side of the bias-free neural predictor's bias weight table. Holds the table index and weight of each in-flight prediction in a FIFO. When the branch resolves, it computes the saturated new bias weight and drives the table's update port (index_update, weight_update, en_1). It sits between the fetch-stage prediction logic and the execute-stage branch resolution.

---
 rtl/bias_weight_updater.sv | 147 ++++++++++++++
 tb/tb_bias_weight_updater.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/bias_weight_updater.sv
// Bias weight table trainer: queues in-flight predictions and writes back the saturated bias weight on resolve.
// Optional macro BIAS_FWD_EN forwards trained weights into queued entries that share the trained index.
module bias_weight_updater #(
    parameter int DEPTH    = 8,
    parameter int INDEX_W  = 10,
    parameter int WEIGHT_W = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pred_valid,
    input  logic [INDEX_W-1:0]         pred_index,
    input  logic [WEIGHT_W-1:0]        pred_weight,
    output logic                       pred_ready,
    input  logic                       resolve_valid,
    input  logic                       resolve_taken,
    input  logic                       flush,
    output logic [INDEX_W-1:0]         index_update,
    output logic [WEIGHT_W-1:0]        weight_update,
    output logic                       en_1,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       underflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic signed [WEIGHT_W-1:0] W_MAX = {1'b0, {(WEIGHT_W-1){1'b1}}};
    localparam logic signed [WEIGHT_W-1:0] W_MIN = {1'b1, {(WEIGHT_W-1){1'b0}}};
    localparam logic signed [WEIGHT_W-1:0] W_ONE = {{(WEIGHT_W-1){1'b0}}, 1'b1};

    logic [PW-1:0]        rd_ptr_reg, wr_ptr_reg;
    logic [CW-1:0]        count_reg, count_next;
    logic                 underflow_reg;
    logic [INDEX_W-1:0]   index_update_reg;
    logic [WEIGHT_W-1:0]  weight_update_reg;
    logic                 en_1_reg;

    logic [INDEX_W-1:0]   idx_arr [DEPTH];
    logic [WEIGHT_W-1:0]  w_arr   [DEPTH];

    logic                 push, pop;
    logic [INDEX_W-1:0]   head_idx;
    logic signed [WEIGHT_W-1:0] head_w;
    logic signed [WEIGHT_W-1:0] w_next;
    logic                 low_conf, predicted_taken, train, write_next;
    logic                 fwd_push;

    assign pred_ready = (count_reg != CW'(DEPTH));
    assign push       = pred_valid && pred_ready && !flush;
    assign pop        = resolve_valid && (count_reg != '0) && !flush;

    assign head_idx = idx_arr[rd_ptr_reg];
    assign head_w   = w_arr[rd_ptr_reg];

    // Weights near zero are low confidence and always trained toward the outcome.
    assign predicted_taken = !head_w[WEIGHT_W-1];
    assign low_conf        = (head_w == '0) || (head_w == '1);
    assign train           = (predicted_taken != resolve_taken) || low_conf;

    always_comb begin
        w_next = head_w;
        if (resolve_taken) begin
            if (head_w != W_MAX) w_next = head_w + W_ONE;
        end else begin
            if (head_w != W_MIN) w_next = head_w - W_ONE;
        end
    end

    assign write_next = pop && train && (w_next != head_w);

`ifdef BIAS_FWD_EN
    assign fwd_push = write_next && (pred_index == head_idx);
`else
    assign fwd_push = 1'b0;
`endif

    // Each entry owns its storage so forwarding can rewrite any matching slot in parallel.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [INDEX_W-1:0]  idx_reg;
            logic [WEIGHT_W-1:0] w_reg;
            logic                wr_sel;

            assign wr_sel = push && (wr_ptr_reg == PW'(gi));

            always_ff @(posedge clk) begin
                if (wr_sel) begin
                    idx_reg <= pred_index;
                    w_reg   <= fwd_push ? w_next : pred_weight;
                end
`ifdef BIAS_FWD_EN
                else if (write_next && (rd_ptr_reg != PW'(gi)) && (idx_reg == head_idx)) begin
                    w_reg <= w_next;
                end
`endif
            end

            assign idx_arr[gi] = idx_reg;
            assign w_arr[gi]   = w_reg;
        end
    endgenerate

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            count_reg     <= '0;
            underflow_reg <= 1'b0;
        end else if (flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
            if (resolve_valid && (count_reg == '0)) underflow_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_1_reg          <= 1'b0;
            index_update_reg  <= '0;
            weight_update_reg <= '0;
        end else begin
            en_1_reg <= write_next;
            if (write_next) begin
                index_update_reg  <= head_idx;
                weight_update_reg <= w_next;
            end
        end
    end

    assign en_1          = en_1_reg;
    assign index_update  = index_update_reg;
    assign weight_update = weight_update_reg;
    assign count         = count_reg;
    assign underflow     = underflow_reg;
endmodule

// File: tb/tb_bias_weight_updater.sv
// Directed, table-driven bench for bias_weight_updater; honours BIAS_FWD_EN when defined.
module tb_bias_weight_updater;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pred_valid = 1'b0;
    logic [9:0] pred_index = '0;
    logic [1:0] pred_weight = '0;
    logic       pred_ready;
    logic       resolve_valid = 1'b0;
    logic       resolve_taken = 1'b0;
    logic       flush = 1'b0;
    logic [9:0] index_update;
    logic [1:0] weight_update;
    logic       en_1;
    logic [3:0] count;
    logic       underflow;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    bias_weight_updater #(.DEPTH(8), .INDEX_W(10), .WEIGHT_W(2)) dut (
        .clk(clk), .rst(rst),
        .pred_valid(pred_valid), .pred_index(pred_index), .pred_weight(pred_weight),
        .pred_ready(pred_ready),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken), .flush(flush),
        .index_update(index_update), .weight_update(weight_update), .en_1(en_1),
        .count(count), .underflow(underflow)
    );

    typedef struct {
        logic       push;
        logic [9:0] idx;
        logic [1:0] w;
        logic       res;
        logic       tk;
        logic       fl;
        logic       en;
        logic [9:0] iu;
        logic [1:0] wu;
        logic [3:0] cnt;
        logic       rdy;
        logic       uf;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic en, input logic [9:0] iu, input logic [1:0] wu,
                           input logic [3:0] cnt, input logic rdy, input logic uf);
        chk({tag, ".en_1"}, int'(en_1), int'(en));
        chk({tag, ".index_update"}, int'(index_update), int'(iu));
        chk({tag, ".weight_update"}, int'(weight_update), int'(wu));
        chk({tag, ".count"}, int'(count), int'(cnt));
        chk({tag, ".pred_ready"}, int'(pred_ready), int'(rdy));
        chk({tag, ".underflow"}, int'(underflow), int'(uf));
    endtask

    task automatic step(input logic p, input logic [9:0] i, input logic [1:0] w,
                        input logic r, input logic t, input logic f);
        pred_valid = p; pred_index = i; pred_weight = w;
        resolve_valid = r; resolve_taken = t; flush = f;
        @(posedge clk);
        #1;
        $display("step push=%0b idx=%0d w=%0d res=%0b tk=%0b fl=%0b -> en_1=%0b iu=%0d wu=%0d count=%0d uf=%0b",
                 p, i, w, r, t, f, en_1, index_update, weight_update, count, underflow);
    endtask

    task automatic do_reset();
        #3 rst = 1'b1;
        pred_valid = 0; resolve_valid = 0; flush = 0;
        @(posedge clk); #3 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        //           push idx w     res tk fl | en iu wu    cnt rdy uf
        vecs[0]  = '{1, 5, 2'b00, 0, 0, 0,  0, 0, 2'b00, 1, 1, 0};
        vecs[1]  = '{0, 0, 2'b00, 1, 1, 0,  1, 5, 2'b01, 0, 1, 0};
        vecs[2]  = '{0, 0, 2'b00, 0, 0, 0,  0, 5, 2'b01, 0, 1, 0};
        vecs[3]  = '{1, 7, 2'b01, 0, 0, 0,  0, 5, 2'b01, 1, 1, 0};
        vecs[4]  = '{0, 0, 2'b00, 1, 1, 0,  0, 5, 2'b01, 0, 1, 0};
        vecs[5]  = '{1, 7, 2'b10, 0, 0, 0,  0, 5, 2'b01, 1, 1, 0};
        vecs[6]  = '{0, 0, 2'b00, 1, 0, 0,  0, 5, 2'b01, 0, 1, 0};
        vecs[7]  = '{1, 9, 2'b11, 0, 0, 0,  0, 5, 2'b01, 1, 1, 0};
        vecs[8]  = '{0, 0, 2'b00, 1, 0, 0,  1, 9, 2'b10, 0, 1, 0};
        vecs[9]  = '{1, 4, 2'b00, 0, 0, 0,  0, 9, 2'b10, 1, 1, 0};
        vecs[10] = '{1, 6, 2'b01, 0, 0, 0,  0, 9, 2'b10, 2, 1, 0};
        vecs[11] = '{1, 8, 2'b10, 1, 1, 0,  1, 4, 2'b01, 2, 1, 0};
        vecs[12] = '{0, 0, 2'b00, 1, 0, 0,  1, 6, 2'b00, 1, 1, 0};
        vecs[13] = '{0, 0, 2'b00, 1, 1, 0,  1, 8, 2'b11, 0, 1, 0};

        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk_all("reset", 0, 0, 2'b00, 0, 1, 0);

        for (int v = 0; v < 14; v++) begin
            step(vecs[v].push, vecs[v].idx, vecs[v].w, vecs[v].res, vecs[v].tk, vecs[v].fl);
            chk_all($sformatf("vec%0d", v), vecs[v].en, vecs[v].iu, vecs[v].wu, vecs[v].cnt, vecs[v].rdy, vecs[v].uf);
        end

        // Fill to DEPTH, then a push with a pop while full must be refused.
        for (int i = 0; i < 8; i++) step(1, 10'(10 + i), 2'b00, 0, 0, 0);
        chk_all("full", 0, 8, 2'b11, 8, 0, 0);
        step(1, 10'd99, 2'b01, 1, 1, 0);
        chk_all("full_push_pop", 1, 10, 2'b01, 7, 1, 0);
        for (int i = 0; i < 7; i++) begin
            step(0, 0, 2'b00, 1, 1, 0);
            chk_all($sformatf("drain%0d", i), 1, 10'(11 + i), 2'b01, 4'(6 - i), 1, 0);
        end

        // Flush drops push and resolve in the same cycle.
        for (int i = 0; i < 3; i++) step(1, 10'(20 + i), 2'b00, 0, 0, 0);
        chk("flush_pre.count", int'(count), 3);
        step(1, 10'd25, 2'b00, 1, 1, 1);
        chk_all("flush", 0, 17, 2'b01, 0, 1, 0);
        step(0, 0, 2'b00, 1, 1, 0);
        chk_all("underflow", 0, 17, 2'b01, 0, 1, 1);
        repeat (3) step(0, 0, 2'b00, 0, 0, 0);
        chk_all("underflow_hold", 0, 17, 2'b01, 0, 1, 1);

        do_reset();
        chk_all("reset2", 0, 0, 2'b00, 0, 1, 0);

        // Two predictions on the same index; forwarding changes the second outcome.
        step(1, 10'd3, 2'b00, 0, 0, 0);
        step(1, 10'd3, 2'b00, 0, 0, 0);
        step(0, 0, 2'b00, 1, 1, 0);
        chk_all("same_idx_1", 1, 3, 2'b01, 1, 1, 0);
        step(0, 0, 2'b00, 1, 1, 0);
`ifdef BIAS_FWD_EN
        chk_all("same_idx_2", 0, 3, 2'b01, 0, 1, 0);
`else
        chk_all("same_idx_2", 1, 3, 2'b01, 0, 1, 0);
`endif

        // Asynchronous reset between edges while en_1 is high.
        for (int i = 0; i < 5; i++) step(1, 10'(40 + i), 2'b00, 0, 0, 0);
        step(0, 0, 2'b00, 1, 1, 0);
        chk_all("pre_async", 1, 40, 2'b01, 4, 1, 0);
        #2 rst = 1'b1;
        #1;
        chk_all("async_rst", 0, 0, 2'b00, 0, 1, 0);
        pred_valid = 0; resolve_valid = 0; flush = 0;
        #1 rst = 1'b0;
        step(0, 0, 2'b00, 0, 0, 0);
        chk_all("post_async", 0, 0, 2'b00, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
